// File: rtl/vga_draw_scheduler.sv
// vga_draw_scheduler: owns the VGA plot port. Redraws the full background from
// ROM after reset or any SCREEN change, and draws 8x8 sprites for two
// requesters with round-robin arbitration on the game screen.
module vga_draw_scheduler #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int SPR_SZ = 8
) (
    input  logic        CLOCK_50,
    input  logic        RESETN,
    input  logic [1:0]  SCREEN,
    input  logic [1:0]  SPR_REQ,
    input  logic [7:0]  SPR_X0,
    input  logic [6:0]  SPR_Y0,
    input  logic [7:0]  SPR_X1,
    input  logic [6:0]  SPR_Y1,
    output logic [1:0]  SPR_GNT,
    output logic [1:0]  SPR_DONE,
    output logic [5:0]  SPR_OFS,
    input  logic [2:0]  SPR_COLOR,
    output logic [16:0] BG_ADDR,
    input  logic [2:0]  BG_COLOR,
    output logic [7:0]  VGA_X,
    output logic [6:0]  VGA_Y,
    output logic [2:0]  VGA_COLOR,
    output logic        VGA_PLOT,
    output logic        BUSY
);

    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST   = 7'(HEIGHT - 1);
    localparam logic [5:0] OFS_LAST = 6'(SPR_SZ * SPR_SZ - 1);
    localparam logic [1:0] SCR_GAME = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        BG_FILL,
        SPRITE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scr_q, scr_d;
    logic        fill_pend_q, fill_pend_d;
    logic        rr_q, rr_d;          // index of the last granted requester
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [5:0]  ofs_q, ofs_d;
    logic [7:0]  sx_q, sx_d;
    logic [6:0]  sy_q, sy_d;
    // one-stage plot pipeline, aligned with the 1-cycle ROM latency
    logic        bg_v_q, bg_v_d;
    logic        spr_v_q, spr_v_d;
    logic [7:0]  slot_x_q, slot_x_d;
    logic [6:0]  slot_y_q, slot_y_d;
    logic [5:0]  slot_ofs_q, slot_ofs_d;
    logic [1:0]  done_q, done_d;

    logic        scr_chg;
    logic        sel;
    logic [8:0]  spr_px;
    logic [7:0]  spr_py;
    logic        spr_plot;

    // Register update with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!RESETN) begin
            state_q     <= IDLE;
            scr_q       <= SCREEN;
            fill_pend_q <= 1'b1;
            rr_q        <= 1'b1;
            x_q         <= '0;
            y_q         <= '0;
            gnt_q       <= '0;
            ofs_q       <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            bg_v_q      <= 1'b0;
            spr_v_q     <= 1'b0;
            slot_x_q    <= '0;
            slot_y_q    <= '0;
            slot_ofs_q  <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            scr_q       <= scr_d;
            fill_pend_q <= fill_pend_d;
            rr_q        <= rr_d;
            x_q         <= x_d;
            y_q         <= y_d;
            gnt_q       <= gnt_d;
            ofs_q       <= ofs_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            bg_v_q      <= bg_v_d;
            spr_v_q     <= spr_v_d;
            slot_x_q    <= slot_x_d;
            slot_y_q    <= slot_y_d;
            slot_ofs_q  <= slot_ofs_d;
            done_q      <= done_d;
        end
    end

    // Next-state: change detect, fill raster walk, sprite arbitration and offset count
    always_comb begin
        state_d     = state_q;
        scr_d       = scr_q;
        fill_pend_d = fill_pend_q;
        rr_d        = rr_q;
        x_d         = x_q;
        y_d         = y_q;
        gnt_d       = gnt_q;
        ofs_d       = ofs_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        bg_v_d      = 1'b0;
        spr_v_d     = 1'b0;
        slot_x_d    = x_q;
        slot_y_d    = y_q;
        slot_ofs_d  = ofs_q;
        done_d      = '0;
        sel         = rr_q ? ~SPR_REQ[0] : SPR_REQ[1];

        scr_chg = (SCREEN != scr_q);
        if (scr_chg) begin
            scr_d       = SCREEN;
            fill_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (fill_pend_q) begin
                    state_d     = BG_FILL;
                    x_d         = '0;
                    y_d         = '0;
                    fill_pend_d = 1'b0;
                end else if (scr_q == SCR_GAME && SPR_REQ != 2'b00) begin
                    state_d = SPRITE;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    rr_d    = sel;
                    sx_d    = sel ? SPR_X1 : SPR_X0;
                    sy_d    = sel ? SPR_Y1 : SPR_Y0;
                    ofs_d   = '0;
                end
            end
            BG_FILL: begin
                bg_v_d = 1'b1;
                // a screen change restarts the walk directly instead of via fill_pend
                if (scr_chg) begin
                    x_d         = '0;
                    y_d         = '0;
                    fill_pend_d = 1'b0;
                end else if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        y_d     = '0;
                        state_d = IDLE;
                    end else begin
                        y_d = y_q + 7'd1;
                    end
                end else begin
                    x_d = x_q + 8'd1;
                end
            end
            SPRITE: begin
                spr_v_d = 1'b1;
                ofs_d   = ofs_q + 6'd1;
                if (ofs_q == OFS_LAST) begin
                    ofs_d   = '0;
                    state_d = IDLE;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Plot slot: background pixel, or clipped non-transparent sprite pixel
    always_comb begin
        spr_px   = {1'b0, sx_q} + {6'b0, slot_ofs_q[2:0]};
        spr_py   = {1'b0, sy_q} + {5'b0, slot_ofs_q[5:3]};
        spr_plot = spr_v_q && (SPR_COLOR != 3'b000) &&
                   (spr_px < 9'(WIDTH)) && (spr_py < 8'(HEIGHT));
        VGA_PLOT  = bg_v_q | spr_plot;
        VGA_X     = '0;
        VGA_Y     = '0;
        VGA_COLOR = '0;
        if (bg_v_q) begin
            VGA_X     = slot_x_q;
            VGA_Y     = slot_y_q;
            VGA_COLOR = BG_COLOR;
        end else if (spr_plot) begin
            VGA_X     = spr_px[7:0];
            VGA_Y     = spr_py[6:0];
            VGA_COLOR = SPR_COLOR;
        end
    end

    assign BG_ADDR  = (state_q == BG_FILL) ? {scr_q, y_q, x_q} : '0;
    assign SPR_GNT  = gnt_q;
    assign SPR_DONE = done_q;
    assign SPR_OFS  = ofs_q;
    assign BUSY     = (state_q != IDLE) || bg_v_q || spr_v_q;

endmodule

// File: tb/tb_vga_draw_scheduler.sv
// tb_vga_draw_scheduler: ROM models, plot scoreboard, sprite clip vector table
// and directed sequences for fill restart, arbitration, screen change and reset.
module tb_vga_draw_scheduler;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  screen;
    logic [1:0]  spr_req;
    logic [7:0]  spr_x0, spr_x1;
    logic [6:0]  spr_y0, spr_y1;
    logic [1:0]  spr_gnt, spr_done;
    logic [5:0]  spr_ofs;
    logic [2:0]  spr_color = '0;
    logic [16:0] bg_addr;
    logic [2:0]  bg_color = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_color;
    logic        vga_plot;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int plot_cnt = 0;
    int last_cyc = 0;
    int spr_mode = 0;
    logic [7:0] last_x = '0;
    logic [6:0] last_y = '0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } plot_t;
    plot_t exp_q[$];

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        int         mode;
        int         exp_cnt;
    } vec_t;

    vga_draw_scheduler #(.WIDTH(160), .HEIGHT(120), .SPR_SZ(8)) dut (
        .CLOCK_50  (clk),
        .RESETN    (resetn),
        .SCREEN    (screen),
        .SPR_REQ   (spr_req),
        .SPR_X0    (spr_x0),
        .SPR_Y0    (spr_y0),
        .SPR_X1    (spr_x1),
        .SPR_Y1    (spr_y1),
        .SPR_GNT   (spr_gnt),
        .SPR_DONE  (spr_done),
        .SPR_OFS   (spr_ofs),
        .SPR_COLOR (spr_color),
        .BG_ADDR   (bg_addr),
        .BG_COLOR  (bg_color),
        .VGA_X     (vga_x),
        .VGA_Y     (vga_y),
        .VGA_COLOR (vga_color),
        .VGA_PLOT  (vga_plot),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] bg_rom(input logic [16:0] a);
        return a[2:0] ^ a[10:8] ^ {1'b0, a[16:15]};
    endfunction

    function automatic logic [2:0] spr_rom(input logic [5:0] o, input logic [1:0] g, input int mode);
        if (mode == 1) return 3'b101;
        if (mode == 2) return 3'b000;
        return (o[2:0] ^ o[5:3]) ^ (g[1] ? 3'b011 : 3'b000);
    endfunction

    // Registered ROM models (1-cycle latency)
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        bg_color  <= bg_rom(bg_addr);
        spr_color <= spr_rom(spr_ofs, spr_gnt, spr_mode);
    end

    // Plot scoreboard
    always @(negedge clk) begin
        if (mon_en && vga_plot === 1'b1) begin
            plot_t e;
            plot_cnt++;
            last_x   = vga_x;
            last_y   = vga_y;
            last_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL plot_unexpected actual=(%0d,%0d,%0d) required=none", vga_x, vga_y, vga_color);
            end else begin
                e = exp_q.pop_front();
                if (vga_x !== e.x || vga_y !== e.y || vga_color !== e.c) begin
                    bad++;
                    $display("FAIL plot actual=(%0d,%0d,%0d) required=(%0d,%0d,%0d)",
                             vga_x, vga_y, vga_color, e.x, e.y, e.c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_raster(input logic [1:0] scr);
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++) begin
                plot_t p;
                p.x = 8'(xx);
                p.y = 7'(yy);
                p.c = bg_rom({scr, 7'(yy), 8'(xx)});
                exp_q.push_back(p);
            end
    endtask

    task automatic push_sprite(input logic [1:0] g, input logic [7:0] sx, input logic [6:0] sy, input int mode);
        for (int o = 0; o < 64; o++) begin
            plot_t p;
            int px, py;
            px = int'(sx) + (o % 8);
            py = int'(sy) + (o / 8);
            p.c = spr_rom(6'(o), g, mode);
            if (p.c != 3'b000 && px < 160 && py < 120) begin
                p.x = 8'(px);
                p.y = 7'(py);
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic wait_idle(input string name, input int bound, output int fall_cyc);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        fall_cyc = cyc;
        chk(name, 32'(busy), 0);
    endtask

    task automatic wait_gnt(input string name, input logic [1:0] req);
        int n = 0;
        while (spr_gnt == 2'b00 && n < 8) begin
            tick();
            n++;
        end
        chk(name, 32'(spr_gnt), 32'(req));
    endtask

    // counts cycles from the grant cycle to the DONE cycle
    task automatic wait_done(input string name, output int c);
        c = 0;
        while (spr_done == 2'b00 && c < 100) begin
            tick();
            c++;
        end
        chk(name, c, 64);
    endtask

    initial begin
        vec_t vec[9];
        int fall, c, base, gcnt, dseen;

        vec[0] = '{8'd10,  7'd10,  1, 64};
        vec[1] = '{8'd152, 7'd112, 1, 64};
        vec[2] = '{8'd156, 7'd117, 1, 12};
        vec[3] = '{8'd156, 7'd117, 2, 0};
        vec[4] = '{8'd159, 7'd119, 1, 1};
        vec[5] = '{8'd200, 7'd5,   1, 0};
        vec[6] = '{8'd3,   7'd125, 1, 0};
        vec[7] = '{8'd40,  7'd60,  0, 56};
        vec[8] = '{8'd155, 7'd0,   1, 40};

        resetn = 1'b0; screen = 2'b00; spr_req = 2'b00;
        spr_x0 = '0; spr_y0 = '0; spr_x1 = '0; spr_y1 = '0;

        // 1: reset state, then full fill of screen 00
        repeat (3) tick();
        chk("rst_plot", 32'(vga_plot), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(spr_gnt), 0);
        chk("rst_done", 32'(spr_done), 0);
        chk("rst_addr", 32'(bg_addr), 0);
        push_raster(2'b00);
        plot_cnt = 0;
        mon_en = 1'b1;
        resetn = 1'b1;
        tick();
        chk("t1_busy", 32'(busy), 1);
        chk("t1_addr0", 32'(bg_addr), 0);
        wait_idle("t1_idle", 19400, fall);
        chk("t1_count", plot_cnt, 19200);
        chk("t1_last_x", 32'(last_x), 159);
        chk("t1_last_y", 32'(last_y), 119);
        chk("t1_busy_fall", fall - last_cyc, 1);
        chk("t1_queue", exp_q.size(), 0);

        // 2: screen change after 5000 plots restarts the fill
        resetn = 1'b0;
        repeat (2) tick();
        exp_q.delete();
        push_raster(2'b00);
        plot_cnt = 0;
        resetn = 1'b1;
        c = 0;
        while (plot_cnt < 5000 && c < 5200) begin
            tick();
            c++;
        end
        chk("t2_5000", plot_cnt, 5000);
        screen = 2'b01;
        tick();
        chk("t2_restart_addr", 32'(bg_addr), 32'({2'b01, 15'd0}));
        exp_q.delete();
        push_raster(2'b01);
        plot_cnt = 0;
        wait_idle("t2_idle", 19400, fall);
        chk("t2_count", plot_cnt, 19200);
        chk("t2_queue", exp_q.size(), 0);

        // 3: both requesters held, round-robin 0,1,0
        spr_mode = 0;
        spr_x0 = 8'd20;  spr_y0 = 7'd30;
        spr_x1 = 8'd100; spr_y1 = 7'd50;
        push_sprite(2'b01, spr_x0, spr_y0, 0);
        push_sprite(2'b10, spr_x1, spr_y1, 0);
        push_sprite(2'b01, spr_x0, spr_y0, 0);
        spr_req = 2'b11;
        tick();
        chk("t3_gnt_a", 32'(spr_gnt), 32'(2'b01));
        wait_done("t3_lat_a", c);
        chk("t3_done_a", 32'(spr_done), 32'(2'b01));
        chk("t3_gnt_drop", 32'(spr_gnt), 0);
        tick();
        chk("t3_done_pulse", 32'(spr_done), 0);
        chk("t3_gnt_b", 32'(spr_gnt), 32'(2'b10));
        wait_done("t3_lat_b", c);
        chk("t3_done_b", 32'(spr_done), 32'(2'b10));
        tick();
        chk("t3_gnt_c", 32'(spr_gnt), 32'(2'b01));
        spr_req = 2'b00;
        wait_done("t3_lat_c", c);
        chk("t3_done_c", 32'(spr_done), 32'(2'b01));
        wait_idle("t3_idle", 10, fall);
        chk("t3_queue", exp_q.size(), 0);

        // 4: clipping / transparency vector table, requester 0
        for (int i = 0; i < 9; i++) begin
            spr_mode = vec[i].mode;
            spr_x0 = vec[i].x;
            spr_y0 = vec[i].y;
            push_sprite(2'b01, spr_x0, spr_y0, spr_mode);
            base = plot_cnt;
            spr_req = 2'b01;
            wait_gnt($sformatf("t4_gnt_%0d", i), 2'b01);
            spr_req = 2'b00;
            wait_done($sformatf("t4_lat_%0d", i), c);
            wait_idle($sformatf("t4_idle_%0d", i), 10, fall);
            chk($sformatf("t4_count_%0d", i), plot_cnt - base, vec[i].exp_cnt);
        end
        chk("t4_queue", exp_q.size(), 0);

        // 6: reset mid-sprite aborts it, then refill from screen 01
        spr_mode = 1;
        spr_x0 = 8'd50; spr_y0 = 7'd50;
        push_sprite(2'b01, spr_x0, spr_y0, 1);
        spr_req = 2'b01;
        wait_gnt("t6_gnt", 2'b01);
        spr_req = 2'b00;
        repeat (10) tick();
        resetn = 1'b0;
        tick();
        chk("t6_gnt", 32'(spr_gnt), 0);
        chk("t6_plot", 32'(vga_plot), 0);
        chk("t6_busy", 32'(busy), 0);
        dseen = (spr_done != 2'b00) ? 1 : 0;
        repeat (2) begin
            tick();
            if (spr_done != 2'b00) dseen = 1;
        end
        exp_q.delete();
        push_raster(2'b01);
        plot_cnt = 0;
        resetn = 1'b1;
        tick();
        if (spr_done != 2'b00) dseen = 1;
        chk("t6_no_done", dseen, 0);
        chk("t6_addr0", 32'(bg_addr), 32'({2'b01, 15'd0}));
        wait_idle("t6_idle", 19400, fall);
        chk("t6_count", plot_cnt, 19200);

        // 5: screen change mid-sprite; sprite completes, then fill on 11
        spr_mode = 0;
        spr_x0 = 8'd70; spr_y0 = 7'd40;
        push_sprite(2'b01, spr_x0, spr_y0, 0);
        push_raster(2'b11);
        spr_req = 2'b01;
        wait_gnt("t5_gnt", 2'b01);
        spr_req = 2'b00;
        c = 0;
        while (spr_done == 2'b00 && c < 100) begin
            tick();
            c++;
            if (c == 20) screen = 2'b11;
        end
        chk("t5_lat", c, 64);
        chk("t5_done", 32'(spr_done), 32'(2'b01));
        tick();
        chk("t5_fill_addr", 32'(bg_addr), 32'({2'b11, 15'd0}));
        base = plot_cnt;
        wait_idle("t5_idle", 19400, fall);
        chk("t5_count", plot_cnt - base, 19200);
        chk("t5_queue", exp_q.size(), 0);
        spr_req = 2'b01;
        gcnt = 0;
        repeat (100) begin
            tick();
            if (spr_gnt != 2'b00 || busy) gcnt++;
        end
        chk("t5_no_grant", gcnt, 0);
        spr_req = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
